// File: rtl/reg_hazard_scoreboard.sv
// reg_hazard_scoreboard
//   Tracks in-flight destination registers between decode and writeback for an
//   RV32E core. Decode presents rs1/rs2/rd of the instruction it wants to issue.
//   issue_ready is withheld on a read-after-write hazard or when the per-register
//   or total tracking capacity is exhausted. Writeback retires destinations.
//
// Ports
//   clock, nreset         : rising-edge clock, asynchronous active-low reset
//   issue_valid           : decode has an instruction to issue
//   issue_ready           : issue permitted this cycle (independent of issue_valid)
//   issue_rs1/_used       : source register 1 index and use flag
//   issue_rs2/_used       : source register 2 index and use flag
//   issue_rd/_used        : destination register index and use flag
//   retire_valid/_rd      : writeback completed a write to retire_rd
//   flush                 : synchronous flush, discards all tracking
//   busy_mask             : bit i set when register i has an outstanding write
//   inflight_count        : total outstanding tracked writes
//   retire_error          : sticky, retire seen for a register with nothing pending
module reg_hazard_scoreboard #(
  parameter int unsigned NUM_REGS     = 16,
  parameter int unsigned MAX_PENDING  = 3,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned CNT_W        = 2,
  parameter int unsigned TOT_W        = 3,
  localparam int unsigned IDX_W       = $clog2(NUM_REGS)
) (
  input  logic                clock,
  input  logic                nreset,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [IDX_W-1:0]    issue_rs1,
  input  logic                issue_rs1_used,
  input  logic [IDX_W-1:0]    issue_rs2,
  input  logic                issue_rs2_used,
  input  logic [IDX_W-1:0]    issue_rd,
  input  logic                issue_rd_used,
  input  logic                retire_valid,
  input  logic [IDX_W-1:0]    retire_rd,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [TOT_W-1:0]    inflight_count,
  output logic                retire_error
);

  logic [CNT_W-1:0] r_cnt [NUM_REGS];
  logic [CNT_W-1:0] w_cnt_next [NUM_REGS];
  logic [TOT_W-1:0] r_total;
  logic [TOT_W-1:0] w_total_next;
  logic             r_retire_error;
  logic             w_retire_error_next;

  logic w_rs1_hazard;
  logic w_rs2_hazard;
  logic w_rd_tracked;
  logic w_rd_full;
  logic w_total_full;
  logic w_fire;
  logic w_inc_en;
  logic w_ret_tracked;
  logic w_dec_en;
  logic w_ret_bad;

  // Issue decision: combinational from registered counters, x0 never tracked.
  always_comb begin
    w_rs1_hazard = issue_rs1_used && (issue_rs1 != '0) && (r_cnt[issue_rs1] != '0);
    w_rs2_hazard = issue_rs2_used && (issue_rs2 != '0) && (r_cnt[issue_rs2] != '0);
    w_rd_tracked = issue_rd_used && (issue_rd != '0);
    w_rd_full    = w_rd_tracked && (r_cnt[issue_rd] == CNT_W'(MAX_PENDING));
    w_total_full = w_rd_tracked && (r_total == TOT_W'(MAX_INFLIGHT));
    issue_ready  = !(flush || w_rs1_hazard || w_rs2_hazard || w_rd_full || w_total_full);
  end

  always_comb begin
    w_fire        = issue_valid && issue_ready;
    w_inc_en      = w_fire && w_rd_tracked;
    w_ret_tracked = retire_valid && (retire_rd != '0) && !flush;
    // Retires of an idle register never decrement, so counters cannot underflow.
    w_dec_en      = w_ret_tracked && (r_cnt[retire_rd] != '0);
    w_ret_bad     = w_ret_tracked && (r_cnt[retire_rd] == '0);
  end

  // Next-state: same-register fire+retire cancels out.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      logic inc_i;
      logic dec_i;
      inc_i = w_inc_en && (issue_rd == IDX_W'(i));
      dec_i = w_dec_en && (retire_rd == IDX_W'(i));
      w_cnt_next[i] = r_cnt[i];
      if (flush) begin
        w_cnt_next[i] = '0;
      end else if (inc_i && !dec_i) begin
        w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
      end else if (dec_i && !inc_i) begin
        w_cnt_next[i] = r_cnt[i] - CNT_W'(1);
      end
    end

    w_total_next = r_total;
    if (flush) begin
      w_total_next = '0;
    end else if (w_inc_en && !w_dec_en) begin
      w_total_next = r_total + TOT_W'(1);
    end else if (w_dec_en && !w_inc_en) begin
      w_total_next = r_total - TOT_W'(1);
    end

    // Flush leaves the sticky error alone; w_ret_bad is already masked by flush.
    w_retire_error_next = r_retire_error || w_ret_bad;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_cnt[i] <= '0;
      end
      r_total        <= '0;
      r_retire_error <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
      r_total        <= w_total_next;
      r_retire_error <= w_retire_error_next;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_mask[i] = (i != 0) && (r_cnt[i] != '0);
    end
    inflight_count = r_total;
    retire_error   = r_retire_error;
  end

endmodule

// File: doc/reg_hazard_scoreboard.md
Name: reg_hazard_scoreboard

Overview:
- Tracks in-flight destination registers between decode and writeback for the RV32E core (16 architectural registers).
- Sits beside the decode stage and gates its downstream handshake.
- Decode presents the rs1/rs2/rd fields of the instruction it is about to issue; the block withholds issue_ready on a read-after-write hazard or on tracking overflow.
- Writeback retires destinations.

Parameters:
- NUM_REGS, 16, architectural registers tracked; index 0 is hardwired zero.
- MAX_PENDING, 3, max outstanding writes per register.
- MAX_INFLIGHT, 4, max outstanding tracked writes in total.
- CNT_W, 2, per-register counter width; must hold MAX_PENDING.
- TOT_W, 3, total counter width; must hold MAX_INFLIGHT.

Ports:
- clock  in  1  clock, rising edge.
- nreset  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  decode has an instruction ready to issue.
- issue_ready  out  1  issue permitted this cycle.
- issue_rs1  in  4  source register 1 index.
- issue_rs1_used  in  1  instruction reads rs1.
- issue_rs2  in  4  source register 2 index.
- issue_rs2_used  in  1  instruction reads rs2.
- issue_rd  in  4  destination register index.
- issue_rd_used  in  1  instruction writes rd.
- retire_valid  in  1  writeback completed a register write this cycle.
- retire_rd  in  4  register written back.
- flush  in  1  synchronous pipeline flush; discards all tracking.
- busy_mask  out  NUM_REGS  bit i set when register i has an outstanding write.
- inflight_count  out  TOT_W  total outstanding tracked writes.
- retire_error  out  1  sticky: a retire arrived for a register with no outstanding write.

Behaviour:
- Reset, asynchronous: all per-register counters and the total counter cleared; retire_error = 0; busy_mask = 0; inflight_count = 0. issue_ready = 1 once nreset deasserts and flush is low.
- Register 0 is never tracked:
  - rd = 0 never increments.
  - rs = 0 never hazards.
  - retire_rd = 0 is ignored.
  - busy_mask[0] is always 0.
- issue_ready is combinational from registered state plus issue_* fields and flush, independent of issue_valid. It is 0 if any of:
  - flush = 1;
  - rs1_used, rs1 != 0 and cnt[rs1] != 0;
  - rs2_used, rs2 != 0 and cnt[rs2] != 0;
  - rd_used, rd != 0 and cnt[rd] == MAX_PENDING;
  - rd_used, rd != 0 and total == MAX_INFLIGHT.
- No same-cycle retire forwarding: a retire in cycle N releases the hazard from cycle N+1.
- Issue fire = issue_valid & issue_ready. On fire with tracked rd, cnt[rd] += 1 and total += 1 at the clock edge. Fire with an untracked rd changes no state.
- Retire:
  - retire_valid with retire_rd != 0 and cnt[retire_rd] != 0: cnt[retire_rd] -= 1 and total -= 1.
  - If cnt[retire_rd] == 0: no state change; retire_error set; it stays set until reset.
- Simultaneous fire and retire:
  - Same register: cnt unchanged, total unchanged.
  - Different registers: each update applies independently; total net unchanged.
- Counters never wrap: overflow is prevented by issue_ready; underflow is prevented by the error rule.
- Flush cycle:
  - All counters cleared at the edge.
  - Retire and issue in that cycle are ignored.
  - retire_error is unaffected.
- busy_mask and inflight_count are derived purely from registered counters: one-cycle visibility after fire or retire.
- Latency: zero-cycle issue decision; state updates visible next cycle.

Test Plan:
- Reset, then issue ADD rd=5 fire -> next cycle busy_mask = 0x0020, inflight_count = 1; issue rs1=5 -> issue_ready = 0. Retire rd=5 -> cycle after, issue_ready = 1 and busy_mask = 0.
- Issue rd=0 writes three times, and reads of rs=0 with x0 "busy" attempts -> issue_ready always 1, busy_mask = 0, inflight_count = 0.
- Fire rd=3 three times -> cnt = 3; fourth issue with rd=3 -> issue_ready = 0. Fire rd=7 -> total = 4; issue with rd=8 -> issue_ready = 0. Issue with rd_used = 0, rs1=9 -> issue_ready = 1.
- With cnt[4] = 1, same cycle fire rd=4 and retire 4 -> cnt[4] stays 1, inflight_count unchanged, busy_mask[4] = 1.
- Retire rd=6 with nothing outstanding -> retire_error = 1 next cycle, counters unchanged. Then flush -> retire_error still 1. Assert nreset low mid-run -> all outputs return to reset values immediately.
- With rd 2, 3, 5 outstanding, assert flush together with retire 2 -> issue_ready = 0 during flush; next cycle busy_mask = 0 and inflight_count = 0.
